// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, aluop codes
// (also used by alu_control_unit), datapath mux selects and FSM state codes.
package mips_pkg;

    localparam int OPCODE_W = 6;
    localparam int ALUOP_W  = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_SLT   = 3'b010;
    localparam logic [2:0] ALUOP_ADD   = 3'b011;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_R_EXEC   = 4'd7;
    localparam logic [3:0] S_R_WB     = 4'd8;
    localparam logic [3:0] S_I_EXEC   = 4'd9;
    localparam logic [3:0] S_I_WB     = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] aluop;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Controller <-> datapath signal bundle. illegal_op exists only when
// ILLEGAL_OPCODE_TRAP_EN is defined.
interface multicycle_main_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                pc_write;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_source;
    logic [ALUOP_W-1:0]  aluop;
    logic                instr_done;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic                illegal_op;
`endif

    modport master (
`ifdef ILLEGAL_OPCODE_TRAP_EN
        output illegal_op,
`endif
        input  opcode, zero, mem_ready,
        output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               aluop, instr_done
    );

    modport slave (
`ifdef ILLEGAL_OPCODE_TRAP_EN
        input  illegal_op,
`endif
        output opcode, zero, mem_ready,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               aluop, instr_done
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath. Defining
// ILLEGAL_OPCODE_TRAP_EN sends unknown opcodes to a sticky TRAP state.
module multicycle_main_control (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_main_control_if.master  bus
);
    import mips_pkg::*;

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_RTYPE:         state_d = S_R_EXEC;
                    OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
`ifdef ILLEGAL_OPCODE_TRAP_EN
                    default:          state_d = S_TRAP;
`else
                    default:          state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are a pure function of state except ir/pc_write in FETCH,
    // the MEM_WR completion pulse, the branch condition and the I-type aluop.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = bus.mem_ready;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.aluop     = ALUOP_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.aluop     = (bus.opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_RT;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pc_source  = PCSRC_ALUOUT;
                ctrl.pc_write   = bus.zero;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.i_or_d     = ctrl.i_or_d;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.pc_source  = ctrl.pc_source;
    assign bus.aluop      = ctrl.aluop;
    assign bus.instr_done = ctrl.instr_done;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign bus.illegal_op = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: expected per-cycle output
// vectors are queued with their stimulus and checked at the falling edge.
module tb_multicycle_main_control;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    multicycle_main_control_if bus ();

    multicycle_main_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rst;
        logic [5:0]  opcode;
        logic        mem_ready;
        logic        zero;
        logic [17:0] exp;
    } step_t;

    step_t q[$];

    // {illegal_op, pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
    //  mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, aluop, instr_done}
    function automatic logic [17:0] v(input logic pw, input logic iod, input logic mrd,
                                      input logic mwr, input logic irw, input logic rdst,
                                      input logic m2r, input logic rw, input logic sa,
                                      input logic [1:0] sb, input logic [1:0] pcs,
                                      input logic [2:0] aop, input logic done);
        return {1'b0, pw, iod, mrd, mwr, irw, rdst, m2r, rw, sa, sb, pcs, aop, done};
    endfunction

    function automatic logic [17:0] e_fetch(input logic mr);
        return v(mr, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 3'b011, 0);
    endfunction
    function automatic logic [17:0] e_decode();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b011, 0);
    endfunction
    function automatic logic [17:0] e_memaddr();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b011, 0);
    endfunction

    localparam logic [17:0] E_IDLE   = 18'd0;
    localparam logic [17:0] E_MEM_RD = 18'b0_0_1_1_0_0_0_0_0_0_00_00_000_0;
    localparam logic [17:0] E_MEM_WB = 18'b0_0_0_0_0_0_0_1_1_0_00_00_000_1;
    localparam logic [17:0] E_R_EXEC = 18'b0_0_0_0_0_0_0_0_0_1_00_00_000_0;
    localparam logic [17:0] E_R_WB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_000_1;
    localparam logic [17:0] E_I_ADD  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_011_0;
    localparam logic [17:0] E_I_SLT  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_010_0;
    localparam logic [17:0] E_I_WB   = 18'b0_0_0_0_0_0_0_0_1_0_00_00_000_1;
    localparam logic [17:0] E_BEQ_T  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_001_1;
    localparam logic [17:0] E_BEQ_N  = 18'b0_0_0_0_0_0_0_0_0_1_00_01_001_1;
    localparam logic [17:0] E_JUMP   = 18'b0_1_0_0_0_0_0_0_0_0_00_10_000_1;
    localparam logic [17:0] E_WR_WT  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_000_0;
    localparam logic [17:0] E_WR_OK  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_000_1;
    localparam logic [17:0] E_TRAP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_000_0;

    task automatic push(input string tag, input logic r, input logic [5:0] op,
                        input logic mr, input logic z, input logic [17:0] exp);
        step_t s;
        s.tag = tag; s.rst = r; s.opcode = op; s.mem_ready = mr; s.zero = z; s.exp = exp;
        q.push_back(s);
    endtask

    function automatic logic [17:0] observe();
        logic ill;
`ifdef ILLEGAL_OPCODE_TRAP_EN
        ill = bus.illegal_op;
`else
        ill = 1'b0;
`endif
        return {ill, bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.pc_source, bus.aluop, bus.instr_done};
    endfunction

    // Each queued step drives inputs for one cycle and checks that cycle's outputs.
    task automatic drain();
        step_t       s;
        logic [17:0] obs;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            rst           = s.rst;
            bus.opcode    = s.opcode;
            bus.mem_ready = s.mem_ready;
            bus.zero      = s.zero;
            #1;
            obs = observe();
            checks++;
            assert (obs === s.exp) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", s.tag, obs, s.exp);
            end
            checks++;
            assert (!(bus.mem_read === 1'b1 && bus.mem_write === 1'b1)) else begin
                errors++;
                $error("FAIL %s_rw_excl observed=%b%b expected=not_both", s.tag,
                       bus.mem_read, bus.mem_write);
            end
            $display("step %-12s t=%0t outputs=%b", s.tag, $time, obs);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.opcode    = 6'b000000;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;

        push("rst_hold", 1, 6'b000000, 1, 0, E_IDLE);
        push("idle",     0, 6'b000000, 1, 0, E_IDLE);

        // LW with a one-cycle fetch stall
        push("lw_fetch_st", 0, 6'b100011, 0, 0, e_fetch(1'b0));
        push("lw_fetch",    0, 6'b100011, 1, 0, e_fetch(1'b1));
        push("lw_decode",   0, 6'b100011, 1, 0, e_decode());
        push("lw_addr",     0, 6'b100011, 1, 0, e_memaddr());
        push("lw_rd",       0, 6'b100011, 1, 0, E_MEM_RD);
        push("lw_wb",       0, 6'b100011, 1, 0, E_MEM_WB);

        push("r_fetch",  0, 6'b000000, 1, 0, e_fetch(1'b1));
        push("r_decode", 0, 6'b000000, 1, 0, e_decode());
        push("r_exec",   0, 6'b000000, 1, 0, E_R_EXEC);
        push("r_wb",     0, 6'b000000, 1, 0, E_R_WB);

        push("addi_fetch", 0, 6'b001000, 1, 0, e_fetch(1'b1));
        push("addi_dec",   0, 6'b001000, 1, 0, e_decode());
        push("addi_exec",  0, 6'b001000, 1, 0, E_I_ADD);
        push("addi_wb",    0, 6'b001000, 1, 0, E_I_WB);

        push("slti_fetch", 0, 6'b001010, 1, 0, e_fetch(1'b1));
        push("slti_dec",   0, 6'b001010, 1, 0, e_decode());
        push("slti_exec",  0, 6'b001010, 1, 0, E_I_SLT);
        push("slti_wb",    0, 6'b001010, 1, 0, E_I_WB);

        push("beq1_fetch", 0, 6'b000100, 1, 1, e_fetch(1'b1));
        push("beq1_dec",   0, 6'b000100, 1, 1, e_decode());
        push("beq1_br",    0, 6'b000100, 1, 1, E_BEQ_T);
        push("beq0_fetch", 0, 6'b000100, 1, 0, e_fetch(1'b1));
        push("beq0_dec",   0, 6'b000100, 1, 0, e_decode());
        push("beq0_br",    0, 6'b000100, 1, 0, E_BEQ_N);

        push("j_fetch", 0, 6'b000010, 1, 0, e_fetch(1'b1));
        push("j_dec",   0, 6'b000010, 1, 0, e_decode());
        push("j_jump",  0, 6'b000010, 1, 0, E_JUMP);

        // SW: three wait cycles, completion pulse, then back to FETCH
        push("sw_fetch", 0, 6'b101011, 1, 0, e_fetch(1'b1));
        push("sw_dec",   0, 6'b101011, 1, 0, e_decode());
        push("sw_addr",  0, 6'b101011, 1, 0, e_memaddr());
        push("sw_wait1", 0, 6'b101011, 0, 0, E_WR_WT);
        push("sw_wait2", 0, 6'b101011, 0, 0, E_WR_WT);
        push("sw_wait3", 0, 6'b101011, 0, 0, E_WR_WT);
        push("sw_wr",    0, 6'b101011, 1, 0, E_WR_OK);

        // LW interrupted by reset while waiting in MEM_RD
        push("lwr_fetch",  0, 6'b100011, 1, 0, e_fetch(1'b1));
        push("lwr_dec",    0, 6'b100011, 1, 0, e_decode());
        push("lwr_addr",   0, 6'b100011, 1, 0, e_memaddr());
        push("lwr_rd_rst", 1, 6'b100011, 0, 0, E_MEM_RD);
        push("lwr_idle",   0, 6'b100011, 1, 0, E_IDLE);

        push("bad_fetch", 0, 6'b111111, 1, 0, e_fetch(1'b1));
        push("bad_dec",   0, 6'b111111, 1, 0, e_decode());
`ifdef ILLEGAL_OPCODE_TRAP_EN
        push("bad_trap1", 0, 6'b111111, 1, 0, E_TRAP);
        push("bad_trap2", 0, 6'b111111, 1, 0, E_TRAP);
`else
        push("bad_refetch", 0, 6'b111111, 1, 0, e_fetch(1'b1));
`endif

        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sits directly upstream of alu_control_unit: decodes the 6-bit opcode, sequences each instruction through its cycles and drives aluop[2:0] plus all datapath enables and muxes.
- Handles variable-latency memory through a mem_ready stall handshake.

Parameters:
- OPCODE_W, 6, opcode width.
- ALUOP_W, 3, width of the aluop bus to alu_control_unit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26] taken from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_write  out  1  load PC.
- i_or_d  out  1  memory address mux: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load IR.
- reg_dst  out  1  write-register mux: 0=rt, 1=rd.
- mem_to_reg  out  1  write-data mux: 0=ALUOut, 1=MDR.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A mux: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B mux: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- pc_source  out  2  PC mux: 00=ALU result, 01=ALUOut, 10=jump target.
- aluop  out  3  to alu_control_unit.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000, SLTI 001010.
- aluop encodings: 000 = R-type (use funct), 001 = subtract, 010 = set-less-than, 011 = add.
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- State register is 4 bits. Outputs are decoded from the state; the only input-dependent terms are those named below.
- Any output not listed for a state is 0.
- rst=1 at a clock edge forces IDLE, including mid-instruction. In IDLE every output is 0. IDLE always goes to FETCH on the next cycle.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, aluop=011, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, aluop=011 (branch target into ALUOut).
  - Next state by opcode: LW/SW→MEM_ADDR, RTYPE→R_EXEC, ADDI/SLTI→I_EXEC, BEQ→BRANCH, J→JUMP, anything else→FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=011. LW→MEM_RD, SW→MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then →MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. →FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1. On that cycle instr_done=1 and next state is FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, aluop=000. →R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. →FETCH.
- I_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - aluop=011 for ADDI, 010 for SLTI, decoded from the opcode held in the IR.
  - →I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. →FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, aluop=001, pc_source=01, pc_write=zero, instr_done=1. →FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1. →FETCH.
- Cycle counts with mem_ready held high:
  - LW 5.
  - SW, R-type, ADDI, SLTI 4.
  - BEQ, J 3.
  - Each mem_ready=0 cycle adds one cycle.
- mem_read and mem_write are never asserted together.
- An unknown opcode costs 2 cycles, writes no state and gives no instr_done.

Optional Feature:
- Macro: ILLEGAL_OPCODE_TRAP_EN.
- Defined:
  - Adds port illegal_op (out, 1) and state TRAP.
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP holds all outputs at 0 except illegal_op=1 and stays there until rst.
- Undefined:
  - No port and no state.
  - Unknown opcodes return to FETCH as above.

Decomposition:
- Package mips_pkg holds:
  - Opcode localparams.
  - aluop encodings (shared with alu_control_unit).
  - State encoding constants.
  - alu_src_b and pc_source encodings.
- No sub-module. Next-state logic and output decode are two always blocks plus one state register in a single module.

Test Plan:
- rst high for 2 cycles, then low → cycle 1 all outputs 0 (IDLE); cycle 2 FETCH with mem_read=1, aluop=011.
- LW (opcode 100011), mem_ready=1 → states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_write=1 and mem_to_reg=1 only in cycle 5; instr_done pulses once.
- R-type (000000) → aluop=000 in cycle 3; reg_write=1 and reg_dst=1 in cycle 4.
- BEQ (000100) with zero=1 → pc_write=1 and pc_source=01 in cycle 3. Repeat with zero=0 → pc_write=0.
- SW with mem_ready low for 3 cycles in MEM_WR → mem_write held for 4 cycles; FETCH on the cycle after mem_ready=1.
- rst asserted during MEM_RD → IDLE next cycle with all outputs 0. Opcode 111111 → DECODE then FETCH (illegal_op=1 and FETCH not re-entered when ILLEGAL_OPCODE_TRAP_EN is defined).
